display_scan_n: RTL and testbench



---
 rtl/display_scan_n_if.sv | 25 ++
 rtl/display_scan_n.sv | 165 ++++++++++++++++
 tb/tb_display_scan_n.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_n_if.sv
// Bus between the counter datapath and the 7-segment scanner:
// nibble/dp data with load strobe, display controls, and pin-side outputs.
interface display_scan_n_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic [3:0]          bright;
  logic                en;
  logic                blank_lz;
  logic [DIGITS-1:0]   sm_wei;
  logic [7:0]          sm_duan;
  logic                frame;

  modport master (
    output data, dp, load, bright, en, blank_lz,
    input  sm_wei, sm_duan, frame
  );

  modport slave (
    input  data, dp, load, bright, en, blank_lz,
    output sm_wei, sm_duan, frame
  );
endinterface

// File: rtl/display_scan_n.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous
// double buffering, PWM brightness, global enable and leading-zero blanking.
module display_scan_n #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 6250
) (
  input  logic             clk,
  input  logic             rst_n,
  display_scan_n_if.slave  bus
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   IW        = $clog2(DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]       tick_q, tick_d;
  logic [3:0]          sub_q, sub_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] stage_data_q, stage_data_d;
  logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   wei_q, wei_d;
  logic [7:0]          duan_q, duan_d;
  logic                frame_q, frame_d;

  logic                tick_wrap, sub_wrap, boundary;
  logic [DIGITS-1:0]   zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_zero, suppress, lit;
  logic                acc;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan counters: sub-tick prescaler, PWM sub-slot, digit index.
  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    sub_wrap  = (sub_q == 4'hF);
    boundary  = tick_wrap && sub_wrap && (idx_q == IDX_LAST);
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    sub_d     = sub_q;
    idx_d     = idx_q;
    if (tick_wrap) begin
      sub_d = sub_q + 1'b1;
      if (sub_wrap) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Staging/display buffers; a load landing on the boundary bypasses staging.
  always_comb begin
    stage_data_d = stage_data_q;
    stage_dp_d   = stage_dp_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (bus.load) begin
      stage_data_d = bus.data;
      stage_dp_d   = bus.dp;
      pending_d    = 1'b1;
    end
    if (boundary) begin
      if (bus.load) begin
        disp_data_d = bus.data;
        disp_dp_d   = bus.dp;
        pending_d   = 1'b0;
      end else if (pending_q) begin
        disp_data_d = stage_data_q;
        disp_dp_d   = stage_dp_q;
        pending_d   = 1'b0;
      end
    end
  end

  // zero_run[i] is set when display nibbles i..DIGITS-1 are all zero.
  always_comb begin
    zero_run = '0;
    acc      = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      acc = acc && (disp_data_q[4*(DIGITS-1-k) +: 4] == 4'h0);
      zero_run[DIGITS-1-k] = acc;
    end
  end

  // Next pin values from the current digit, sub-slot and live controls.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = disp_data_q[4*i +: 4];
        cur_dp   = disp_dp_q[i];
        cur_zero = zero_run[i];
      end
    end
    suppress = bus.blank_lz && cur_zero && (idx_q != '0);
    lit      = bus.en && (sub_q <= bus.bright);
    wei_d    = '1;
    duan_d   = 8'hFF;
    if (lit) begin
      wei_d  = ~(DIGITS'(1) << idx_q);
      duan_d = {~cur_dp, suppress ? 7'h7F : seg7(cur_nib)};
    end
    frame_d = boundary;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q       <= '0;
      sub_q        <= '0;
      idx_q        <= '0;
      stage_data_q <= '0;
      stage_dp_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      wei_q        <= '1;
      duan_q       <= 8'hFF;
      frame_q      <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      sub_q        <= sub_d;
      idx_q        <= idx_d;
      stage_data_q <= stage_data_d;
      stage_dp_q   <= stage_dp_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      wei_q        <= wei_d;
      duan_q       <= duan_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.sm_wei  = wei_q;
  assign bus.sm_duan = duan_q;
  assign bus.frame   = frame_q;

endmodule

// File: tb/tb_display_scan_n.sv
// Scoreboard bench for display_scan_n (DIGITS=4, TICK_DIV=2): a frame-position
// reference model predicts each cycle's pins, a monitor compares them.
module tb_display_scan_n;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned TICK_DIV = 2;
  localparam int unsigned SLOT     = 16 * TICK_DIV;
  localparam int unsigned FRAME    = DIGITS * SLOT;

  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [3:0] wei;
    logic [7:0] duan;
    logic       frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_n_if #(.DIGITS(DIGITS)) bus ();

  display_scan_n #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned mc = 0;
  logic [15:0] m_stage = '0, m_disp = '0;
  logic [3:0]  m_stage_dp = '0, m_disp_dp = '0;
  bit          m_pend = 1'b0;

  // Reference model: frame position from a plain cycle count since reset.
  initial begin
    exp_t        e;
    int unsigned pos, dig, sub;
    logic [7:0]  code;
    logic [15:0] hi;
    bit          blank;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        e = '{wei: 4'hF, duan: 8'hFF, frame: 1'b0};
        mc = 0; m_stage = '0; m_disp = '0; m_stage_dp = '0; m_disp_dp = '0; m_pend = 1'b0;
      end else begin
        pos = mc % FRAME;
        dig = pos / SLOT;
        sub = (pos % SLOT) / TICK_DIV;
        e.frame = (pos == FRAME - 1);
        if (bus.en && sub <= int'(bus.bright)) begin
          e.wei = ~(4'b0001 << dig);
          code  = SEG[m_disp[4*dig +: 4]];
          hi    = m_disp >> (4 * dig);
          blank = bus.blank_lz && (dig > 0) && (hi == 16'h0);
          e.duan = {~m_disp_dp[dig], blank ? 7'h7F : code[6:0]};
        end else begin
          e.wei  = 4'hF;
          e.duan = 8'hFF;
        end
        if (bus.load) begin
          m_stage = bus.data; m_stage_dp = bus.dp; m_pend = 1'b1;
        end
        if (pos == FRAME - 1) begin
          if (bus.load) begin
            m_disp = bus.data; m_disp_dp = bus.dp; m_pend = 1'b0;
          end else if (m_pend) begin
            m_disp = m_stage; m_disp_dp = m_stage_dp; m_pend = 1'b0;
          end
        end
        mc++;
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: compare pins away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.sm_wei !== e.wei || bus.sm_duan !== e.duan || bus.frame !== e.frame) begin
          errors++;
          $display("FAIL pins t=%0t mc=%0d got wei=%h duan=%h frame=%b exp wei=%h duan=%h frame=%b",
                   $time, mc, bus.sm_wei, bus.sm_duan, bus.frame, e.wei, e.duan, e.frame);
        end
      end
    end
  end

  task automatic goto_pos(input int unsigned k);
    int unsigned n = 0;
    while ((mc % FRAME) != k) begin
      @(negedge clk);
      n++;
      if (n > 2 * FRAME) begin
        checks++;
        errors++;
        $display("FAIL goto_pos timeout got pos=%0d exp pos=%0d", mc % FRAME, k);
        return;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.data = d;
    bus.dp   = p;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    bus.data = '0; bus.dp = '0; bus.load = 1'b0;
    bus.bright = 4'd15; bus.en = 1'b1; bus.blank_lz = 1'b0;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Basic load, old data persists until the boundary.
    goto_pos(10);
    do_load(16'h1234, 4'b0000);
    goto_pos(0);
    goto_pos(100);

    // Tearing: two loads in one frame, then a load on the boundary cycle.
    goto_pos(40);
    do_load(16'hAAAA, 4'b0000);
    goto_pos(60);
    do_load(16'hBBBB, 4'b0000);
    goto_pos(0);
    goto_pos(FRAME - 1);
    do_load(16'hCCCC, 4'b0000);
    run(FRAME);

    // Brightness and enable.
    bus.bright = 4'd3;
    run(FRAME);
    bus.en = 1'b0;
    run(FRAME + 40);
    bus.en = 1'b1;
    bus.bright = 4'd15;

    // Leading-zero suppression with a dp on a blanked digit.
    bus.blank_lz = 1'b1;
    do_load(16'h0050, 4'b1000);
    run(2 * FRAME);
    bus.blank_lz = 1'b0;
    run(FRAME);

    // Reset mid-scan.
    goto_pos(50);
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      run($urandom_range(1, 90));
      case ($urandom_range(0, 5))
        0, 1: begin
          d = 16'($urandom);
          d = d >> (4 * $urandom_range(0, 4));
          do_load(d, 4'($urandom));
        end
        2: begin
          goto_pos(FRAME - 1);
          do_load(16'($urandom), 4'($urandom));
        end
        3: bus.bright = 4'($urandom);
        4: bus.en = ($urandom_range(0, 3) != 0);
        default: bus.blank_lz = 1'($urandom);
      endcase
    end
    bus.en = 1'b1;
    run(FRAME);

    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
